apb_master_arb: RTL and testbench

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_master_arb_if.sv | 33 +++
 rtl/apb_master_arb.sv | 105 ++++++++++
 tb/tb_apb_master_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arb_if.sv
// Requester and APB completer bundle for apb_master_arb.
// master modport is the arbiter side; slave modport is the requester/completer side.
interface apb_master_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA,
        output req_ready, rsp_valid, rsp_rdata,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_arb.sv
// Multi-requester APB master: arbitrates requesters onto one APB completer.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module apb_master_arb #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input logic              PCLK,
    input logic              PRESET,
    apb_master_arb_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cur_gnt;
    logic             gnt_any;
    logic             gnt_take;
`ifndef APB_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] last_grant;
`endif

    // Loops run from lowest to highest priority so the best candidate is written last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
`ifdef APB_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
`else
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
`endif
    end

    always_comb begin
        gnt_take = gnt_any && !PRESET &&
                   (state == IDLE || state == ACCESS);
        bus.req_ready = gnt_take ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_take) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = gnt_take ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            cur_gnt       <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
            last_grant    <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            bus.rsp_valid <= '0;
            if (state == SETUP) bus.PENABLE <= 1'b1;
            if (state == ACCESS) begin
                bus.rsp_valid <= NUM_REQ'(1) << cur_gnt;
                bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
                bus.PSEL      <= 1'b0;
                bus.PENABLE   <= 1'b0;
            end
            // A new grant overrides the ACCESS wind-down, keeping PSEL high back-to-back.
            if (gnt_take) begin
                bus.PSEL    <= 1'b1;
                bus.PENABLE <= 1'b0;
                bus.PWRITE  <= bus.req_write[gnt_idx];
                bus.PADDR   <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
                bus.PWDATA  <= bus.req_write[gnt_idx] ?
                               bus.req_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
                cur_gnt     <= gnt_idx;
`ifndef APB_ARB_FIXED_PRIO_EN
                last_grant  <= gnt_idx;
`endif
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: single read/write, back-to-back
// arbitration, dropped request, and reset mid-transfer.
module tb_apb_master_arb;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_master_arb_if #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) bus ();

    apb_master_arb #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic w,
                           input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        bus.req_write[i] = w;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    logic [NUM_REQ-1:0] exp_rdy [4];
    logic [ADDR_W-1:0]  exp_addr;

    initial begin
`ifdef APB_ARB_FIXED_PRIO_EN
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b01;
        exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b01;
`else
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10;
        exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
`endif
        PRESET        = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = 32'hDEADBEEF;
        tick;
        tick;

        // reset state
        chk("rst_psel", bus.PSEL, 1'b0);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_pwrite", bus.PWRITE, 1'b0);
        chk("rst_paddr", bus.PADDR, 8'h00);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        bus.req_valid = 2'b11;
        #1;
        chk("rst_ready", bus.req_ready, 2'b00);
        bus.req_valid = 2'b00;
        tick;
        PRESET = 1'b0;
        tick;

        // single read from requester 0
        set_req(0, 1'b0, 8'h10, 32'h0);
        bus.req_valid = 2'b01;
        #1;
        chk("rd_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        #1;
        chk("rd_setup_psel", bus.PSEL, 1'b1);
        chk("rd_setup_pen", bus.PENABLE, 1'b0);
        chk("rd_setup_paddr", bus.PADDR, 8'h10);
        chk("rd_setup_pwrite", bus.PWRITE, 1'b0);
        chk("rd_setup_pwdata", bus.PWDATA, 32'h0);
        chk("rd_setup_ready", bus.req_ready, 2'b00);
        tick;
        chk("rd_acc_psel", bus.PSEL, 1'b1);
        chk("rd_acc_pen", bus.PENABLE, 1'b1);
        chk("rd_acc_paddr", bus.PADDR, 8'h10);
        chk("rd_acc_rsp", bus.rsp_valid, 2'b00);
        tick;
        chk("rd_rsp_valid", bus.rsp_valid, 2'b01);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("rd_done_psel", bus.PSEL, 1'b0);
        tick;
        chk("rd_rsp_pulse", bus.rsp_valid, 2'b00);
        chk("rd_rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);

        // single write from requester 1
        set_req(1, 1'b1, 8'h24, 32'h12345678);
        bus.req_valid = 2'b10;
        #1;
        chk("wr_ready", bus.req_ready, 2'b10);
        tick;
        bus.req_valid = 2'b00;
        chk("wr_setup_pwrite", bus.PWRITE, 1'b1);
        chk("wr_setup_paddr", bus.PADDR, 8'h24);
        chk("wr_setup_pwdata", bus.PWDATA, 32'h12345678);
        tick;
        chk("wr_acc_pen", bus.PENABLE, 1'b1);
        chk("wr_acc_pwrite", bus.PWRITE, 1'b1);
        chk("wr_acc_paddr", bus.PADDR, 8'h24);
        chk("wr_acc_pwdata", bus.PWDATA, 32'h12345678);
        tick;
        chk("wr_rsp_valid", bus.rsp_valid, 2'b10);
        chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        tick;

        // back-to-back with both requesters held valid
        set_req(0, 1'b0, 8'h30, 32'h0);
        set_req(1, 1'b0, 8'h44, 32'h0);
        bus.req_valid = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("b2b_ready%0d", t), bus.req_ready, exp_rdy[t]);
            exp_addr = (exp_rdy[t] == 2'b01) ? 8'h30 : 8'h44;
            tick;
            if (t == 3) bus.req_valid = 2'b00;
            chk($sformatf("b2b_psel_s%0d", t), bus.PSEL, 1'b1);
            chk($sformatf("b2b_pen_s%0d", t), bus.PENABLE, 1'b0);
            chk($sformatf("b2b_paddr%0d", t), bus.PADDR, exp_addr);
            if (t > 0)
                chk($sformatf("b2b_rsp%0d", t - 1), bus.rsp_valid,
                    exp_rdy[t-1]);
            tick;
            chk($sformatf("b2b_psel_a%0d", t), bus.PSEL, 1'b1);
            chk($sformatf("b2b_pen_a%0d", t), bus.PENABLE, 1'b1);
        end
        chk("b2b_last_ready", bus.req_ready, 2'b00);
        tick;
        chk("b2b_rsp3", bus.rsp_valid, exp_rdy[3]);
        chk("b2b_end_psel", bus.PSEL, 1'b0);
        tick;

        // requester 1 pulses only during SETUP of requester 0
        bus.req_valid = 2'b01;
        #1;
        chk("drop_ready0", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b10;
        #1;
        chk("drop_setup_ready", bus.req_ready, 2'b00);
        tick;
        bus.req_valid = 2'b00;
        #1;
        chk("drop_acc_ready", bus.req_ready, 2'b00);
        tick;
        chk("drop_idle_psel", bus.PSEL, 1'b0);
        chk("drop_rsp", bus.rsp_valid, 2'b01);
        tick;
        chk("drop_still_idle", bus.PSEL, 1'b0);
        chk("drop_no_rsp", bus.rsp_valid, 2'b00);

        // reset asserted during ACCESS
        set_req(1, 1'b1, 8'h24, 32'h12345678);
        bus.req_valid = 2'b10;
        #1;
        chk("rstm_ready", bus.req_ready, 2'b10);
        tick;
        bus.req_valid = 2'b00;
        tick;
        chk("rstm_acc_pen", bus.PENABLE, 1'b1);
        PRESET = 1'b1;
        tick;
        PRESET = 1'b0;
        chk("rstm_psel", bus.PSEL, 1'b0);
        chk("rstm_pen", bus.PENABLE, 1'b0);
        chk("rstm_pwrite", bus.PWRITE, 1'b0);
        chk("rstm_paddr", bus.PADDR, 8'h00);
        chk("rstm_pwdata", bus.PWDATA, 32'h0);
        chk("rstm_rsp", bus.rsp_valid, 2'b00);
        chk("rstm_rdata", bus.rsp_rdata, 32'h0);
        bus.req_valid = 2'b11;
        #1;
        chk("rstm_first_grant", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        tick;
        chk("rstm_no_rsp", bus.rsp_valid, 2'b00);
        tick;
        chk("rstm_rsp0", bus.rsp_valid, 2'b01);
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
